key_schedule_ctrl: RTL and testbench
====================================

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, 10 rounds fixed.
REQ-002 i_Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_Rst  in  1  reset, synchronous, active-high.
REQ-004 i_Start  in  1  start request, sampled only in IDLE.
REQ-005 i_Key  in  128  cipher key, latched on accepted start.
REQ-006 i_fDec  in  1  mode, latched on accepted start: 0 = encrypt order, 1 = decrypt order.
REQ-007 o_Busy  out  1  high in any state other than IDLE.
REQ-008 o_Done  out  1  one-cycle pulse after the final round key handshake.
REQ-009 o_RoundKey  out  128  presented round key.
REQ-010 o_Round  out  4  index (0..10) of the presented round key.
REQ-011 o_KeyValid  out  1  o_RoundKey/o_Round valid.
REQ-012 i_KeyReady  in  1  consumer accepts the key; a transfer occurs when o_KeyValid and i_KeyReady are both high.
REQ-013 o_KE_Key  out  128  current key to the external expansion unit, equal to the internal key register.
REQ-014 o_KE_Round  out  4  step index to the expansion unit, equal to the internal step counter.
REQ-015 o_KE_fDec  out  1  direction to the expansion unit: 0 in PREP, latched mode in OUT.
REQ-016 i_KE_Key  in  128  combinational next key returned by the expansion unit.

Function
REQ-017 State SHALL be one of IDLE, PREP, OUT, held in registers r_Key[127:0], r_Cnt[3:0], r_Dec.
REQ-018 IDLE, i_Start=1: r_Key<=i_Key, r_Dec<=i_fDec, r_Cnt<=0; next state PREP if i_fDec=1, else OUT.
REQ-019 PREP (decrypt only) SHALL forward-expand for exactly 10 cycles with r_Key<=i_KE_Key and r_Cnt<=r_Cnt+1 each cycle, and o_KeyValid=0.
REQ-020 When r_Cnt=9 in PREP, the block SHALL load r_Key<=i_KE_Key, set r_Cnt<=0 and move to OUT, so r_Key then holds round-10 key.
REQ-021 OUT SHALL drive o_KeyValid=1, o_RoundKey=r_Key, and o_Round = r_Cnt (encrypt) or 10-r_Cnt (decrypt).
REQ-022 In OUT, a transfer with r_Cnt<10 SHALL load r_Key<=i_KE_Key and increment r_Cnt; with no transfer, all outputs hold.
REQ-023 In OUT, a transfer with r_Cnt=10 SHALL return the block to IDLE and assert o_Done in the next cycle only.
REQ-024 Sequence per job: 11 transfers, keys 0..10 in encrypt mode, keys 10..0 in decrypt mode.
REQ-025 Latency from accepted start to first o_KeyValid: 1 cycle in encrypt mode, 11 cycles in decrypt mode; back-to-back transfers at 1 key/cycle when i_KeyReady is held high.
REQ-026 i_Start SHALL be ignored in PREP and OUT; i_KeyReady SHALL be ignored when o_KeyValid=0.
REQ-027 i_Start in the o_Done cycle SHALL be accepted, because the block is in IDLE.
REQ-028 o_RoundKey outside OUT SHALL equal r_Key, not guaranteed meaningful.
REQ-029 The only combinational path through the block SHALL be i_KE_Key to r_Key; no output depends combinationally on i_KeyReady or i_Start.

Reset
REQ-030 i_Rst=1 SHALL force IDLE, r_Key=0, r_Cnt=0, r_Dec=0, o_Busy=0, o_Done=0, o_KeyValid=0, o_Round=0, o_RoundKey=0, o_KE_fDec=0 at the next edge.
REQ-031 i_Rst SHALL take priority over i_Start and any handshake, including during PREP or OUT; the job is abandoned with no o_Done.

Verification
REQ-032 Encrypt, key 2b7e151628aed2a6abf7158809cf4f3c, ready always 1 -> o_Round 0..10 on consecutive cycles; round 1 key = a0fafe1788542cb123a339392a6c7605; round 10 key = d014f9a8c9ee2589e13f0cc8b6630ca6; o_Done one cycle later.
REQ-033 Decrypt, same key -> o_KeyValid first rises 11 cycles after start with o_Round=10, key d014f9a8...b6630ca6; last transfer has o_Round=0 and key 2b7e1516...09cf4f3c.
REQ-034 Random i_KeyReady stalls -> key/round stable while stalled; no key skipped or repeated; exactly 11 transfers.
REQ-035 i_Start pulsed during PREP and OUT with a different i_Key -> ignored; current sequence unchanged.
REQ-036 i_Rst asserted mid-OUT (o_Round=5) -> next cycle all outputs at reset values, no o_Done; a new start then runs a full sequence correctly.
REQ-037 i_Start held high across o_Done -> new job accepted in the o_Done cycle; first valid key of the new job 1 cycle later (encrypt mode).

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// AES-128 round-key sequencer. Walks an external combinational expansion unit through
// the 11 round keys, in forward order for encryption or reverse order for decryption,
// and hands each key to a consumer over a valid/ready handshake.
module key_schedule_ctrl (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Start,
  input  logic [127:0] i_Key,
  input  logic         i_fDec,
  output logic         o_Busy,
  output logic         o_Done,
  output logic [127:0] o_RoundKey,
  output logic [3:0]   o_Round,
  output logic         o_KeyValid,
  input  logic         i_KeyReady,
  output logic [127:0] o_KE_Key,
  output logic [3:0]   o_KE_Round,
  output logic         o_KE_fDec,
  input  logic [127:0] i_KE_Key
);

  localparam logic [3:0] LastRound = 4'd10;
  localparam logic [3:0] LastPrep  = 4'd9;

  typedef enum logic [1:0] {StIdle, StPrep, StOut} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         dec_q, dec_d;
  logic         done_q, done_d;

  logic out_st;
  logic xfer;

  assign out_st = (state_q == StOut);
  assign xfer   = out_st & i_KeyReady;

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          key_d   = i_Key;
          dec_d   = i_fDec;
          cnt_d   = 4'd0;
          state_d = i_fDec ? StPrep : StOut;
        end
      end
      StPrep: begin
        // Run the forward expansion to round 10 so decryption can walk backwards.
        key_d = i_KE_Key;
        if (cnt_q == LastPrep) begin
          cnt_d   = 4'd0;
          state_d = StOut;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StOut: begin
        if (xfer) begin
          if (cnt_q == LastRound) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            key_d = i_KE_Key;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from registers; nothing depends on i_Start or i_KeyReady.
  always_comb begin
    o_Busy     = (state_q != StIdle);
    o_Done     = done_q;
    o_KeyValid = out_st;
    o_RoundKey = key_q;
    o_Round    = 4'd0;
    if (out_st) begin
      o_Round = dec_q ? (LastRound - cnt_q) : cnt_q;
    end
    o_KE_Key   = key_q;
    o_KE_Round = cnt_q;
    o_KE_fDec  = out_st & dec_q;
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: models the external expansion unit, computes the full
// AES-128 schedule per job and checks order, timing, stalls, reset and back-to-back starts.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, fdec, ready;
  logic [127:0] key;
  logic [127:0] ke_key_in;
  logic         busy, done, valid, ke_fdec;
  logic [127:0] rkey, ke_key_out;
  logic [3:0]   round, ke_round;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [127:0] obs_r1, obs_r10;

  localparam logic [127:0] KeyA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyR1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KeyR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  key_schedule_ctrl dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Start    (start),
    .i_Key      (key),
    .i_fDec     (fdec),
    .o_Busy     (busy),
    .o_Done     (done),
    .o_RoundKey (rkey),
    .o_Round    (round),
    .o_KeyValid (valid),
    .i_KeyReady (ready),
    .o_KE_Key   (ke_key_out),
    .o_KE_Round (ke_round),
    .o_KE_fDec  (ke_fdec),
    .i_KE_Key   (ke_key_in)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (a != 8'h00 && gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r = 8'h01;
    for (int j = 0; j < i; j++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input int i);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_rot(k[31:0]) ^ {rcon(i), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input int i);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rcon(i), 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // External expansion unit: forward step to the next round, or inverse step back one.
  always_comb begin
    if (ke_fdec) ke_key_in = inv_step(ke_key_out, (ke_round <= 4'd9) ? 9 - int'(ke_round) : 0);
    else ke_key_in = fwd_step(ke_key_out, (ke_round <= 4'd9) ? int'(ke_round) : 0);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_round", round, 0);
    chk("rst_rkey", rkey, 0);
    chk("rst_ke_fdec", ke_fdec, 0);
    chk("rst_ke_key", ke_key_out, 0);
  endtask

  // One complete job. skip_start: job already accepted by a held start. chain: keep start
  // high with next_k across the final transfer so the next job is taken in the done cycle.
  task automatic run_job(input logic [127:0] k, input bit dec, input int pct, input bit noise,
                         input bit skip_start, input bit chain, input logic [127:0] next_k);
    logic [127:0] rk[11];
    int idx, cyc, lat, exp_r;
    bit rdy;
    rk[0] = k;
    for (int i = 1; i <= 10; i++) rk[i] = fwd_step(rk[i-1], i - 1);
    if (!skip_start) begin
      @(negedge clk);
      start = 1'b1;
      key   = k;
      fdec  = dec;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = dec ? 11 : 1;
    idx = 0;
    cyc = 0;
    while (idx < 11 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      chk("busy", busy, 1);
      chk("valid", valid, (cyc >= lat) ? 1 : 0);
      if (valid) begin
        exp_r = dec ? 10 - idx : idx;
        chk("round", round, exp_r);
        chk("rkey", rkey, rk[exp_r]);
        chk("ke_fdec_out", ke_fdec, dec);
        if (round == 4'd1) obs_r1 = rkey;
        if (round == 4'd10) obs_r10 = rkey;
      end else begin
        chk("ke_fdec_prep", ke_fdec, 0);
      end
      rdy   = ($urandom_range(0, 99) < pct);
      ready = rdy;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        key   = {$urandom, $urandom, $urandom, $urandom};
        fdec  = 1'($urandom_range(0, 1));
      end
      if (valid && rdy) begin
        idx++;
        if (idx == 11) begin
          start = chain;
          key   = next_k;
          fdec  = 1'b0;
        end
      end
    end
    chk("transfers", idx, 11);
    @(negedge clk);
    ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("idle_busy", busy, 0);
    chk("idle_valid", valid, 0);
    if (!chain) begin
      start = 1'b0;
      @(negedge clk);
      chk("done_once", done, 0);
    end
  endtask

  initial begin
    logic [127:0] k2;
    int cyc;
    rst = 1'b1; start = 1'b0; key = '0; fdec = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // Reference vector, encrypt then decrypt, consumer always ready.
    run_job(KeyA, 1'b0, 100, 1'b0, 1'b0, 1'b0, '0);
    chk("enc_r1", obs_r1, KeyR1);
    chk("enc_r10", obs_r10, KeyR10);
    run_job(KeyA, 1'b1, 100, 1'b0, 1'b0, 1'b0, '0);
    chk("dec_r10", obs_r10, KeyR10);

    // Random keys with consumer stalls, and ignored starts during PREP/OUT.
    run_job({$urandom, $urandom, $urandom, $urandom}, 1'b0, 50, 1'b0, 1'b0, 1'b0, '0);
    run_job({$urandom, $urandom, $urandom, $urandom}, 1'b1, 40, 1'b1, 1'b0, 1'b0, '0);
    run_job({$urandom, $urandom, $urandom, $urandom}, 1'b0, 60, 1'b1, 1'b0, 1'b0, '0);

    // Reset in the middle of OUT at round 5.
    @(negedge clk);
    start = 1'b1; key = {$urandom, $urandom, $urandom, $urandom}; fdec = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    ready = 1'b1;
    cyc = 0;
    while (round != 4'd5 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_round5", round, 5);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    chk("rst_no_done", done, 0);
    chk("rst_idle", busy, 0);
    run_job(KeyA, 1'b0, 100, 1'b0, 1'b0, 1'b0, '0);
    chk("post_rst_r10", obs_r10, KeyR10);

    // Start held across done: new job accepted in the done cycle.
    k2 = {$urandom, $urandom, $urandom, $urandom};
    run_job({$urandom, $urandom, $urandom, $urandom}, 1'b1, 100, 1'b0, 1'b0, 1'b1, k2);
    run_job(k2, 1'b0, 70, 1'b0, 1'b1, 1'b0, '0);

    for (int j = 0; j < 3; j++) begin
      run_job({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
              $urandom_range(30, 90), 1'b1, 1'b0, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
